draw_engine: RTL
================

Name: draw_engine

Overview:
- Pixel-drawing responder for the race-game control FSM.
- Accepts level-held draw requests (start screen, background, car, over-car, win screen) and rasterises the requested region.
- Fetches colours from external image ROMs and drives VGA-adapter pixel writes.
- Returns sticky per-operation done flags that the control FSM samples combinationally.

Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- CAR_W, 8, car sprite width
- CAR_H, 8, car sprite height
- TRANSPARENT, 3'b000, car-sprite colour that is not plotted

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- clear_done  in  1  from control set_reset_signals; clears all done flags
- draw_start_screen  in  1  request: full-screen start image
- draw_background  in  1  request: full-screen track image
- draw_car  in  1  request: car sprite at car position
- draw_over_car  in  1  request: restore background under car
- draw_win_screen  in  1  request: full-screen win image
- car_x  in  8  car top-left x
- car_y  in  7  car top-left y
- rom_sel  out  2  image select: 0 start, 1 background, 2 car, 3 win
- rom_addr  out  15  ROM address
- rom_data  in  3  colour; valid one cycle after rom_addr
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write strobe
- DoneDrawStartScreen  out  1  sticky done
- DoneDrawBackground  out  1  sticky done
- DoneDrawCar  out  1  sticky done
- DoneDrawOverCar  out  1  sticky done
- DoneDrawWinScreen  out  1  sticky done

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States:
  - IDLE: wait for a request.
  - RUN: issue one address per cycle.
  - FLUSH: one cycle to emit the final pixel.
  - HOLD: done set, wait for the request to drop or change.
- Request priority, if several are high: start > win > background > over_car > car. The accepted op is latched; car_x/car_y are latched at accept.
- Accept: in IDLE or HOLD, a request high for a different op than the latched one is accepted.
  - All five done flags clear in the accept cycle.
  - A request for the same op held high in HOLD does not redraw.
- Full-screen ops: counter cx 0..SCR_W-1 (inner), cy 0..SCR_H-1; rom_addr = cy*SCR_W+cx.
- Car op: sx 0..CAR_W-1, sy 0..CAR_H-1; rom_sel=2; rom_addr = sy*CAR_W+sx; pixel at (car_x+sx, car_y+sy).
- Over-car op: same region as car, rom_sel=1; rom_addr = (car_y+sy)*SCR_W+(car_x+sx).
- Timing, with accept at cycle 0:
  - Cycle 1: first address issued.
  - Cycle k+1: pixel k output.
  - Last pixel output at cycle N+1.
  - Done flag high from cycle N+2, state HOLD.
- Pipeline: vga_x/vga_y are registered one stage behind the address counters so they align with rom_data. vga_colour = rom_data.
- vga_plot is low when:
  - not in the output stage,
  - the car op returns rom_data==TRANSPARENT,
  - the pixel x>=SCR_W or y>=SCR_H (clipped; still counted).
- Done flags stay high through HOLD and IDLE until the next accept, clear_done, or Reset. The control FSM sees DoneDrawCar low on each re-entry to car drawing because an over-car or background draw intervenes.
- Request dropped mid-RUN: abort to IDLE, vga_plot low from the next cycle, no done set.
- Reset or clear_done mid-operation: Reset aborts to IDLE; clear_done only clears flags, and an in-flight op still completes and sets its flag.
- Arithmetic:
  - Address math uses 15-bit unsigned.
  - car_x+sx is computed 9 bits wide and car_y+sy 8 bits wide before the clip compare; no wrap-around.

Decomposition:
- Shared package: rom_sel encodings, op codes, SCR_W/SCR_H, TRANSPARENT.
- Natural sub-module: raster_counter (nested x/y counter with programmable width/height, start, abort, last flag).

Test Plan:
- Background request after Reset (SCR 160x120) -> 19200 plots, first vga_plot at cycle 2 at (0,0), last at (159,119) on cycle 19201; DoneDrawBackground high at cycle 19202 and held.
- draw_car with car_x=20, car_y=30, sprite corners TRANSPARENT -> 64 addresses, plots only at non-transparent pixels, e.g. (21,31); DoneDrawCar rises; subsequent draw_over_car clears it in its accept cycle.
- draw_car with car_x=156, car_y=116 -> pixels with x>=160 or y>=120 not plotted; done still after 64 pixel slots.
- draw_start_screen held high after done for 100 cycles -> no further plots, DoneDrawStartScreen stays 1; clear_done pulse -> flag 0, no redraw.
- draw_background dropped at cycle 50 -> vga_plot 0 from cycle 51, state IDLE, DoneDrawBackground stays 0; Reset asserted mid-car draw -> all outputs 0 next cycle.
- draw_win_screen and draw_car raised in the same cycle -> win op accepted, rom_sel=3, only DoneDrawWinScreen set.

Source files
------------

// File: rtl/draw_engine_pkg.sv
// Shared encodings for the draw engine: ROM image selects, operation codes,
// FSM states and screen/sprite geometry.
package draw_engine_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int CAR_W = 8;
  localparam int CAR_H = 8;
  localparam logic [2:0] TRANSPARENT = 3'b000;

  typedef enum logic [1:0] {
    SEL_START = 2'd0,
    SEL_BG    = 2'd1,
    SEL_CAR   = 2'd2,
    SEL_WIN   = 2'd3
  } rom_sel_t;

  // Op codes double as the bit index of the matching request/done flag.
  typedef enum logic [2:0] {
    OP_START = 3'd0,
    OP_BG    = 3'd1,
    OP_CAR   = 3'd2,
    OP_OVER  = 3'd3,
    OP_WIN   = 3'd4,
    OP_NONE  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_HOLD
  } state_t;

  // Priority: start > win > background > over_car > car.
  function automatic op_t pick_op(input logic [4:0] req);
    if (req[0]) return OP_START;
    if (req[4]) return OP_WIN;
    if (req[1]) return OP_BG;
    if (req[3]) return OP_OVER;
    if (req[2]) return OP_CAR;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/draw_engine_raster_counter.sv
// Nested x/y scan counter over a width x height region; last flags the
// final coordinate of the scan.
module draw_engine_raster_counter (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       abort,
  input  logic       step,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic       x_end;
  logic       y_end;

  always_comb begin
    x_end = (x_reg == width - 8'd1);
    y_end = (y_reg == height - 7'd1);
    last  = x_end && y_end;
  end

  always_ff @(posedge Clock) begin
    if (Reset || start || abort) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (step) begin
      if (x_end) begin
        x_reg <= '0;
        y_reg <= y_end ? 7'd0 : y_reg + 7'd1;
      end else begin
        x_reg <= x_reg + 8'd1;
      end
    end
  end

  assign x = x_reg;
  assign y = y_reg;

endmodule

// File: rtl/draw_engine.sv
// Rasterising responder for the race-game control FSM: scans the requested
// region, reads colours from the image ROMs and drives VGA pixel writes.
module draw_engine
  import draw_engine_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clear_done,
  input  logic        draw_start_screen,
  input  logic        draw_background,
  input  logic        draw_car,
  input  logic        draw_over_car,
  input  logic        draw_win_screen,
  input  logic [7:0]  car_x,
  input  logic [6:0]  car_y,
  output logic [1:0]  rom_sel,
  output logic [14:0] rom_addr,
  input  logic [2:0]  rom_data,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        DoneDrawStartScreen,
  output logic        DoneDrawBackground,
  output logic        DoneDrawCar,
  output logic        DoneDrawOverCar,
  output logic        DoneDrawWinScreen
);

  state_t     state_reg, state_next;
  op_t        op_reg, op_next, req_op;
  logic [7:0] car_x_reg;
  logic [6:0] car_y_reg;
  logic [4:0] done_reg, done_next;
  logic       out_valid_reg, clip_reg;
  logic [7:0] vga_x_reg;
  logic [6:0] vga_y_reg;

  logic [4:0] req_vec, other_req;
  logic       req_held, accept, abort_run, is_car_region;
  logic [7:0] cnt_x, area_w;
  logic [6:0] cnt_y, area_h;
  logic       cnt_last;
  logic [8:0] pix_x;
  logic [7:0] pix_y;

  assign req_vec = {draw_win_screen, draw_over_car, draw_car, draw_background, draw_start_screen};

  // The latched op's own line is masked so a held request never re-triggers.
  always_comb begin
    other_req = req_vec;
    req_held  = 1'b0;
    if (op_reg != OP_NONE) begin
      other_req[op_reg] = 1'b0;
      req_held          = req_vec[op_reg];
    end
    req_op    = pick_op(other_req);
    accept    = ((state_reg == ST_IDLE) || (state_reg == ST_HOLD)) && (req_op != OP_NONE);
    abort_run = (state_reg == ST_RUN) && !req_held;
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    done_next  = done_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_RUN;
      ST_RUN: begin
        if (abort_run)     state_next = ST_IDLE;
        else if (cnt_last) state_next = ST_FLUSH;
      end
      ST_FLUSH: state_next = ST_HOLD;
      ST_HOLD: begin
        if (accept)         state_next = ST_RUN;
        else if (!req_held) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
    if (accept)         op_next = req_op;
    else if (abort_run) op_next = OP_NONE;
    if (accept || clear_done) done_next = '0;
    if ((state_reg == ST_FLUSH) && (op_reg != OP_NONE)) done_next[op_reg] = 1'b1;
  end

  always_comb begin
    is_car_region = (op_reg == OP_CAR) || (op_reg == OP_OVER);
    area_w        = is_car_region ? 8'(CAR_W) : 8'(SCR_W);
    area_h        = is_car_region ? 7'(CAR_H) : 7'(SCR_H);
    pix_x         = {1'b0, cnt_x};
    pix_y         = {1'b0, cnt_y};
    if (is_car_region) begin
      pix_x = {1'b0, car_x_reg} + {1'b0, cnt_x};
      pix_y = {1'b0, car_y_reg} + {1'b0, cnt_y};
    end
  end

  always_comb begin
    rom_sel  = SEL_START;
    rom_addr = '0;
    if (state_reg == ST_RUN) begin
      case (op_reg)
        OP_START: begin rom_sel = SEL_START; rom_addr = 15'(cnt_y) * 15'(SCR_W) + 15'(cnt_x); end
        OP_BG:    begin rom_sel = SEL_BG;    rom_addr = 15'(cnt_y) * 15'(SCR_W) + 15'(cnt_x); end
        OP_WIN:   begin rom_sel = SEL_WIN;   rom_addr = 15'(cnt_y) * 15'(SCR_W) + 15'(cnt_x); end
        OP_CAR:   begin rom_sel = SEL_CAR;   rom_addr = 15'(cnt_y) * 15'(CAR_W) + 15'(cnt_x); end
        OP_OVER:  begin rom_sel = SEL_BG;    rom_addr = 15'(pix_y) * 15'(SCR_W) + 15'(pix_x); end
        default:  begin rom_sel = SEL_START; rom_addr = '0; end
      endcase
    end
  end

  draw_engine_raster_counter u_raster (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (accept),
    .abort  (abort_run),
    .step   (state_reg == ST_RUN),
    .width  (area_w),
    .height (area_h),
    .x      (cnt_x),
    .y      (cnt_y),
    .last   (cnt_last)
  );

  // Pixel coordinates trail the address by one cycle to line up with rom_data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_NONE;
      done_reg      <= '0;
      car_x_reg     <= '0;
      car_y_reg     <= '0;
      out_valid_reg <= 1'b0;
      clip_reg      <= 1'b0;
      vga_x_reg     <= '0;
      vga_y_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      done_reg      <= done_next;
      out_valid_reg <= (state_reg == ST_RUN) && !abort_run;
      if (accept) begin
        car_x_reg <= car_x;
        car_y_reg <= car_y;
      end
      if (state_reg == ST_RUN) begin
        vga_x_reg <= pix_x[7:0];
        vga_y_reg <= pix_y[6:0];
        clip_reg  <= (pix_x >= 9'(SCR_W)) || (pix_y >= 8'(SCR_H));
      end else begin
        vga_x_reg <= '0;
        vga_y_reg <= '0;
        clip_reg  <= 1'b0;
      end
    end
  end

  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = out_valid_reg ? rom_data : 3'b000;
  assign vga_plot   = out_valid_reg && !clip_reg && !((op_reg == OP_CAR) && (rom_data == TRANSPARENT));

  assign DoneDrawStartScreen = done_reg[0];
  assign DoneDrawBackground  = done_reg[1];
  assign DoneDrawCar         = done_reg[2];
  assign DoneDrawOverCar     = done_reg[3];
  assign DoneDrawWinScreen   = done_reg[4];

endmodule
